// File: rtl/lane_byte_tx.sv
// Single-lane D-PHY style HS transmitter: LP11->LP01->LP00 entry, HS-zero preamble, sync 0xB8,
// payload at 2 bits/clock (LSB pair first), trailer and LP11 exit. Registered outputs, 1 byte per 4 cycles.
module lane_byte_tx #(
  parameter int T_LPX     = 4,
  parameter int T_HS_ZERO = 2,
  parameter int T_TRAIL   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       lp_p,
  output logic       lp_n,
  output logic       hs_oe,
  output logic [1:0] ddr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    STOP, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT
  } state_t;

  localparam logic [7:0] LPX_LD   = 8'(T_LPX - 1);
  localparam logic [7:0] ZERO_LD  = 8'(T_HS_ZERO - 1);
  localparam logic [7:0] TRAIL_LD = 8'(T_TRAIL - 1);
  localparam logic [7:0] SYNC_B   = 8'hB8;

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [7:0] sh, sh_nxt;
  logic [1:0] beat, beat_nxt;
  logic       lastbit, lastbit_nxt;

  // Byte-long phases count beats and only step the timer when a byte completes.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    sh_nxt      = sh;
    beat_nxt    = beat;
    lastbit_nxt = lastbit;
    case (state)
      STOP: begin
        if (byte_valid) begin
          state_nxt = HS_RQST;
          timer_nxt = LPX_LD;
        end
      end
      HS_RQST: begin
        if (timer == 8'd0) begin
          state_nxt = HS_PREP;
          timer_nxt = LPX_LD;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      HS_PREP: begin
        if (timer == 8'd0) begin
          state_nxt = HS_ZERO;
          timer_nxt = ZERO_LD;
          beat_nxt  = 2'd0;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      HS_ZERO: begin
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) begin
          if (timer == 8'd0) begin
            state_nxt = HS_SYNC;
            sh_nxt    = SYNC_B;
          end else begin
            timer_nxt = timer - 8'd1;
          end
        end
      end
      HS_SYNC, HS_DATA: begin
        beat_nxt = beat + 2'd1;
        // Beat 3 is the ready cycle: take the next byte or close the packet.
        if (beat == 2'd3) begin
          lastbit_nxt = sh[7];
          if (byte_valid) begin
            state_nxt = HS_DATA;
            sh_nxt    = byte_in;
          end else begin
            state_nxt = HS_TRAIL;
            timer_nxt = TRAIL_LD;
          end
        end
      end
      HS_TRAIL: begin
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) begin
          if (timer == 8'd0) begin
            state_nxt = HS_EXIT;
            timer_nxt = LPX_LD;
          end else begin
            timer_nxt = timer - 8'd1;
          end
        end
      end
      HS_EXIT: begin
        if (timer == 8'd0) begin
          state_nxt = STOP;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= STOP;
      timer      <= 8'd0;
      sh         <= 8'd0;
      beat       <= 2'd0;
      lastbit    <= 1'b0;
      lp_p       <= 1'b1;
      lp_n       <= 1'b1;
      hs_oe      <= 1'b0;
      ddr_data   <= 2'b00;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      sh         <= sh_nxt;
      beat       <= beat_nxt;
      lastbit    <= lastbit_nxt;
      lp_p       <= (state_nxt == STOP) || (state_nxt == HS_EXIT);
      lp_n       <= (state_nxt == STOP) || (state_nxt == HS_RQST) || (state_nxt == HS_EXIT);
      hs_oe      <= (state_nxt == HS_ZERO) || (state_nxt == HS_SYNC) ||
                    (state_nxt == HS_DATA) || (state_nxt == HS_TRAIL);
      byte_ready <= ((state_nxt == HS_SYNC) || (state_nxt == HS_DATA)) && (beat_nxt == 2'd3);
      busy       <= (state_nxt != STOP);
      case (state_nxt)
        HS_SYNC, HS_DATA: ddr_data <= sh_nxt[{beat_nxt, 1'b0} +: 2];
        HS_TRAIL:         ddr_data <= {2{~lastbit_nxt}};
        default:          ddr_data <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_byte_tx.sv
// Scoreboard bench for lane_byte_tx: default-parameter instance plus a T_*=1 instance,
// every expected output cycle is queued when a packet is launched and compared at negedge.
module tb_lane_byte_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] din0, din1;
  logic       vld0, vld1;
  logic       rdy0, rdy1;
  logic       lpp0, lpn0, lpp1, lpn1;
  logic       oe0, oe1;
  logic [1:0] ddr0, ddr1;
  logic       busy0, busy1;

  lane_byte_tx u_dut0 (
    .clk(clk), .rstn(rstn), .byte_in(din0), .byte_valid(vld0), .byte_ready(rdy0),
    .lp_p(lpp0), .lp_n(lpn0), .hs_oe(oe0), .ddr_data(ddr0), .busy(busy0)
  );

  lane_byte_tx #(.T_LPX(1), .T_HS_ZERO(1), .T_TRAIL(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .byte_in(din1), .byte_valid(vld1), .byte_ready(rdy1),
    .lp_p(lpp1), .lp_n(lpn1), .hs_oe(oe1), .ddr_data(ddr1), .busy(busy1)
  );

  typedef struct packed {
    logic [1:0] lp;
    logic       oe;
    logic [1:0] ddr;
    logic       rdy;
    logic       busy;
  } obs_t;

  typedef struct {
    int   cyc;
    bit   u1;
    obs_t o;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] pkt[$];
  int         cyc;
  int         checks;
  int         errors;
  obs_t       obs0, obs1;
  localparam int NOLIM = 32'h3fffffff;

  assign obs0 = {lpp0, lpn0, oe0, ddr0, rdy0, busy0};
  assign obs1 = {lpp1, lpn1, oe1, ddr1, busy1 == busy1 ? rdy1 : 1'b0, busy1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t ex;
    obs_t got;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      ex  = sbq.pop_front();
      got = ex.u1 ? obs1 : obs0;
      chk($sformatf("u%0d c%0d cyc", ex.u1, ex.cyc), 32'(cyc), 32'(ex.cyc));
      chk($sformatf("u%0d c%0d lp", ex.u1, ex.cyc), 32'(got.lp), 32'(ex.o.lp));
      chk($sformatf("u%0d c%0d hs_oe", ex.u1, ex.cyc), 32'(got.oe), 32'(ex.o.oe));
      chk($sformatf("u%0d c%0d ddr", ex.u1, ex.cyc), 32'(got.ddr), 32'(ex.o.ddr));
      chk($sformatf("u%0d c%0d ready", ex.u1, ex.cyc), 32'(got.rdy), 32'(ex.o.rdy));
      chk($sformatf("u%0d c%0d busy", ex.u1, ex.cyc), 32'(got.busy), 32'(ex.o.busy));
    end
  end

  task automatic put(input int c, input bit u1, input logic [1:0] lp, input logic oe,
                     input logic [1:0] ddr, input logic rdy, input logic bsy, input int lim);
    exp_t e;
    if (c >= lim) return;
    e.cyc = c;
    e.u1  = u1;
    e.o   = {lp, oe, ddr, rdy, bsy};
    sbq.push_back(e);
  endtask

  // Expected line activity for a packet whose valid first rises during cycle base.
  task automatic push_pkt(input int base, input bit u1, input int tl, input int tz, input int tt,
                          input int lim, output int stop_c);
    int         c;
    logic [7:0] b;
    logic       last;
    c = base + 1;
    for (int i = 0; i < tl; i++) begin put(c, u1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, lim); c++; end
    for (int i = 0; i < tl; i++) begin put(c, u1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, lim); c++; end
    for (int i = 0; i < 4 * tz; i++) begin put(c, u1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, lim); c++; end
    b    = 8'hB8;
    last = b[7];
    for (int k = 0; k < 4; k++) begin put(c, u1, 2'b00, 1'b1, b[2*k +: 2], k == 3, 1'b1, lim); c++; end
    for (int j = 0; j < pkt.size(); j++) begin
      b = pkt[j];
      for (int k = 0; k < 4; k++) begin put(c, u1, 2'b00, 1'b1, b[2*k +: 2], k == 3, 1'b1, lim); c++; end
      last = b[7];
    end
    for (int i = 0; i < 4 * tt; i++) begin
      put(c, u1, 2'b00, 1'b1, last ? 2'b00 : 2'b11, 1'b0, 1'b1, lim);
      c++;
    end
    for (int i = 0; i < tl; i++) begin put(c, u1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, lim); c++; end
    put(c, u1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, lim);
    stop_c = c;
  endtask

  task automatic set_src(input bit u1, input logic v, input logic [7:0] d);
    if (u1) begin vld1 = v; din1 = d; end
    else begin vld0 = v; din0 = d; end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // Reactive source: offers pkt bytes, advances on valid&ready, drops valid after the last.
  task automatic drive_src(input bit u1);
    int n;
    int idx;
    int guard;
    bit acc;
    n = pkt.size();
    idx = 0;
    guard = 0;
    set_src(u1, 1'b1, n > 0 ? pkt[0] : 8'hA5);
    if (n == 0) begin
      @(posedge clk); #1;
      set_src(u1, 1'b0, 8'h00);
      return;
    end
    while (idx < n && guard < 200) begin
      @(negedge clk);
      acc = u1 ? (rdy1 && vld1) : (rdy0 && vld0);
      @(posedge clk); #1;
      guard++;
      if (acc) idx++;
      if (idx < n) set_src(u1, 1'b1, pkt[idx]);
      else set_src(u1, 1'b0, 8'h00);
    end
    if (idx < n) chk("src_accept_timeout", 32'(idx), 32'(n));
  endtask

  task automatic run_pkt(input bit u1);
    int base;
    int stop_c;
    base = cyc;
    if (u1) push_pkt(base, 1'b1, 1, 1, 1, NOLIM, stop_c);
    else    push_pkt(base, 1'b0, 4, 2, 2, NOLIM, stop_c);
    drive_src(u1);
    wait_to(stop_c + 2);
  endtask

  initial begin
    int base;
    int stop_c;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    set_src(1'b0, 1'b0, 8'h00);
    set_src(1'b1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst lp", 32'({lpp0, lpn0}), 32'd3);
    chk("rst hs_oe", 32'(oe0), 32'd0);
    chk("rst ddr", 32'(ddr0), 32'd0);
    chk("rst ready", 32'(rdy0), 32'd0);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst1 lp", 32'({lpp1, lpn1}), 32'd3);
    chk("rst1 busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_to(cyc + 2);

    // Single byte, then three back-to-back bytes, then sync-only.
    pkt = '{8'h5A};
    run_pkt(1'b0);
    pkt = '{8'hFF, 8'h00, 8'h81};
    run_pkt(1'b0);
    pkt.delete();
    run_pkt(1'b0);

    // Reset mid HS_DATA, then a fresh request right after.
    base = cyc;
    pkt = '{8'h11, 8'h22};
    push_pkt(base, 1'b0, 4, 2, 2, base + 22, stop_c);
    put(base + 22, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, NOLIM);
    put(base + 23, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, NOLIM);
    set_src(1'b0, 1'b1, 8'h11);
    wait_to(base + 21);
    set_src(1'b0, 1'b1, 8'h22);
    rstn = 1'b0;
    wait_to(base + 22);
    rstn = 1'b1;
    set_src(1'b0, 1'b0, 8'h00);
    wait_to(base + 23);
    pkt = '{8'hC3};
    run_pkt(1'b0);

    // Valid re-raised during trailer and held through exit: no ready, STOP, then new request.
    base = cyc;
    pkt = '{8'h5A};
    push_pkt(base, 1'b0, 4, 2, 2, NOLIM, stop_c);
    put(base + 38, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, NOLIM);
    put(base + 39, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, NOLIM);
    drive_src(1'b0);
    wait_to(base + 26);
    set_src(1'b0, 1'b1, 8'hEE);
    wait_to(base + 38);
    rstn = 1'b0;
    wait_to(base + 39);
    rstn = 1'b1;
    set_src(1'b0, 1'b0, 8'h00);
    wait_to(base + 41);

    // Minimum timing parameters.
    pkt = '{8'hA7};
    run_pkt(1'b1);
    pkt = '{8'h3C, 8'hD2};
    run_pkt(1'b1);

    // Random payload.
    pkt.delete();
    for (int i = 0; i < 5; i++) pkt.push_back(8'($urandom_range(0, 255)));
    run_pkt(1'b0);

    wait_to(cyc + 2);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
